sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port synchronous SRAM between the instruction-fetch port (IF) and the MEM stage data port.
- Sequences each access through issue, latency wait and response. Generates the stall signals that freeze IF and MEM while their access is outstanding.
- Data port has priority. A starvation counter guarantees fetch progress.
- Sits between the pipeline stages and the external SRAM interface.

Parameters:
- LAT, 1, SRAM read latency in cycles from issue to valid sram_rdata; legal 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while inst_req is pending before IF is forced to win; legal 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush; cancels or drops instruction-port transactions.
- inst_req  input  1  IF requests a fetch; held stable until inst_valid.
- inst_addr  input  32  fetch address, word aligned.
- inst_rdata  output  32  fetched word; meaningful when inst_valid=1.
- inst_valid  output  1  one-cycle fetch completion.
- inst_stall  output  1  combinational: inst_req & !inst_valid.
- data_req  input  1  MEM requests a load or store; held stable until data_valid.
- data_addr  input  32  data address, already error-checked and masked by MEM.
- data_wen  input  4  byte write enables; 0 means read.
- data_wdata  input  32  lane-aligned store data.
- data_rdata  output  32  raw SRAM word for loads; valid with data_valid.
- data_valid  output  1  one-cycle data completion; writes also get it as an ack.
- data_stall  output  1  combinational: data_req & !data_valid.
- sram_en  output  1  SRAM access strobe.
- sram_addr  output  32  SRAM address.
- sram_wen  output  4  SRAM byte write enables.
- sram_wdata  output  32  SRAM write data.
- sram_rdata  input  32  SRAM read data.

Behaviour:
- State: owner register (INST/DATA), write flag, drop flag, latency counter of 3 bits, 4-bit starve_cnt.
- Reset:
  - state IDLE; all outputs 0 except the combinational stalls; starve_cnt, counter, drop flag and rdata registers 0.
  - Reset mid-transaction aborts it: no valid is raised, sram_en is 0 from the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Grant to data if data_req, unless inst_req=1 and starve_cnt==STARVE_MAX; then grant to inst.
  - Otherwise grant to inst if inst_req=1 and flush=0.
  - On a grant, latch owner, address, wen (forced 0 for inst) and wdata, then go to ISSUE. No request means stay in IDLE.
- starve_cnt:
  - Increments (saturating) on a data grant while inst_req=1.
  - Clears on an inst grant, or any cycle inst_req=0.
- ISSUE, exactly one cycle:
  - sram_en=1 and sram_addr/sram_wen/sram_wdata driven from the latched values. All sram_* outputs are 0 in every other state.
  - Write (wen!=0): next state RESP.
  - Read: next state WAIT with counter=1.
- WAIT:
  - When counter==LAT, capture sram_rdata into the owner's rdata register and go to RESP; otherwise increment the counter.
- RESP, one cycle:
  - Assert the owner's valid, unless owner=INST and the drop flag is set; the drop flag is cleared here.
  - Next state IDLE; no arbitration happens in RESP.
- Latency from a request seen in IDLE:
  - read: valid at cycle LAT+2 after the grant cycle.
  - write: valid 2 cycles after the grant cycle.
  - Throughput is one access per LAT+3 cycles for reads and 3 cycles for writes.
- flush:
  - In IDLE, blocks an inst grant that cycle; a data grant is still allowed.
  - In ISSUE or WAIT with owner=INST, sets the drop flag. The SRAM read still completes and inst_valid is suppressed.
  - Data transactions are never affected by flush.
- Simultaneous inst_req and data_req in IDLE follow the priority rule above. The loser's stall stays high.
- rdata registers hold their value until the next capture for the same port.

Test Plan:
- LAT=1, inst_req=1 addr 0x00400000 (SRAM returns 0x24080001) -> sram_en=1 for exactly 1 cycle with sram_addr=0x00400000, sram_wen=0; inst_valid=1 at grant+3 with inst_rdata=0x24080001; inst_stall=1 until then.
- LAT=2, inst_req and data_req (load 0x10010004) both high -> data granted first; data_valid at grant+4; inst granted in the next IDLE cycle; inst_stall held throughout.
- STARVE_MAX=2, data_req and inst_req held high continuously -> grant order DATA, DATA, INST, DATA, DATA, INST; starve_cnt is 0 after each inst grant.
- Store data_wen=4'b1100, addr 0x10010008, wdata 0xABCD0000 -> one sram_en pulse with sram_wen=4'b1100 and sram_wdata=0xABCD0000; data_valid at grant+2; no WAIT state.
- LAT=3, inst fetch; flush pulsed during WAIT -> SRAM read completes, inst_valid stays 0, FSM returns to IDLE; the following inst_req is served normally.
- rst asserted during WAIT of a data read -> next cycle state IDLE, all outputs 0, no data_valid; after rst deasserts, a held data_req is re-granted.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the fetch port and the
// MEM-stage data port; data wins unless fetch has been starved STARVE_MAX times.
module sram_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_stall,
  output logic        sram_en,
  output logic [31:0] sram_addr,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [2:0] LAT_C    = 3'(LAT);
  localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);
  localparam logic       OWN_INST = 1'b0;
  localparam logic       OWN_DATA = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic        drop_q, drop_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        force_inst, grant_data, grant_inst;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid   = 1'b0;
    data_valid   = 1'b0;
    sram_en      = 1'b0;
    sram_addr    = '0;
    sram_wen     = '0;
    sram_wdata   = '0;
    grant_data   = 1'b0;
    grant_inst   = 1'b0;
    // A flushed fetch cannot win, so starvation only overrides data when IF could take the slot.
    force_inst   = inst_req && !flush && (starve_q == STARVE_C);

    case (state_q)
      IDLE: begin
        grant_data = data_req && !force_inst;
        grant_inst = !grant_data && inst_req && !flush;
        if (grant_data || grant_inst) begin
          owner_d = grant_data ? OWN_DATA : OWN_INST;
          wr_d    = grant_data && (data_wen != 4'b0);
          addr_d  = grant_data ? data_addr : inst_addr;
          wen_d   = grant_data ? data_wen : 4'b0;
          wdata_d = grant_data ? data_wdata : 32'b0;
          drop_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        sram_en    = 1'b1;
        sram_addr  = addr_q;
        sram_wen   = wen_q;
        sram_wdata = wdata_q;
        if (flush && owner_q == OWN_INST) drop_d = 1'b1;
        if (wr_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 3'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush && owner_q == OWN_INST) drop_d = 1'b1;
        if (cnt_q == LAT_C) begin
          if (owner_q == OWN_DATA) data_rdata_d = sram_rdata;
          else                     inst_rdata_d = sram_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        data_valid = (owner_q == OWN_DATA);
        inst_valid = (owner_q == OWN_INST) && !drop_q;
        drop_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!inst_req || grant_inst)
      starve_d = '0;
    else if (grant_data && starve_q != STARVE_C)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      wr_q         <= 1'b0;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
      starve_q     <= '0;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      drop_q       <= drop_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_stall = inst_req & ~inst_valid;
  assign data_stall = data_req & ~data_valid;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected SRAM issues
// and port responses; a negedge monitor pops and compares them.
module tb_sram_port_arbiter;
  localparam int LAT        = 2;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [3:0]  data_wen = '0;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        inst_valid, inst_stall, data_valid, data_stall, sram_en;
  logic [3:0]  sram_wen;

  sram_port_arbiter #(.LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_stall(inst_stall),
    .data_req(data_req), .data_addr(data_addr), .data_wen(data_wen),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .data_stall(data_stall), .sram_en(sram_en), .sram_addr(sram_addr),
    .sram_wen(sram_wen), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: fixed contents plus one writable overlay word, LAT-deep read pipe.
  function automatic logic [31:0] base_word(input logic [31:0] a);
    case (a)
      32'h00400000: return 32'h24080001;
      32'h00400004: return 32'h24090002;
      32'h00400008: return 32'h240A0003;
      32'h0040000C: return 32'h240B0004;
      32'h10010004: return 32'h11112222;
      32'h10010008: return 32'h55556666;
      32'h10010010: return 32'hA0A0A0A0;
      32'h10010014: return 32'hB1B1B1B1;
      32'h10010018: return 32'hC2C2C2C2;
      32'h1001001C: return 32'hD3D3D3D3;
      32'h10010020: return 32'h77778888;
      default:      return 32'hBAD0BAD0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  logic        ov_vld = 1'b0;
  logic [31:0] ov_addr = '0, ov_data = '0, cur_word;
  logic [31:0] rd_pipe [LAT];
  assign cur_word   = (ov_vld && ov_addr == sram_addr) ? ov_data : base_word(sram_addr);
  assign sram_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    rd_pipe[0] <= (sram_en && sram_wen == 4'b0) ? cur_word : 32'hDEADBEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (sram_en && sram_wen != 4'b0) begin
      ov_vld  <= 1'b1;
      ov_addr <= sram_addr;
      ov_data <= merge(cur_word, sram_wdata, sram_wen);
    end
  end

  typedef struct { bit is_data; logic [31:0] rdata; int cyc; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; int cyc; } sram_t;
  resp_t resp_q[$];
  sram_t sram_q[$];
  resp_t mon_r;
  sram_t mon_s;
  int    nvec = 0, nerr = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_read(input bit is_data, input logic [31:0] a, input logic [31:0] d,
                          input int g);
    sram_q.push_back('{a, 4'b0, 32'b0, g + 1});
    resp_q.push_back('{is_data, d, g + LAT + 2});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] hold, input int g);
    sram_q.push_back('{a, be, wd, g + 1});
    resp_q.push_back('{1'b1, hold, g + 2});
  endtask

  always @(negedge clk) if (mon_en) begin
    if (inst_valid || data_valid) begin
      chk("single_valid", 32'(inst_valid & data_valid), 32'd0);
      if (resp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL resp_unexpected @cyc %0d: inst_valid=%b data_valid=%b, want none",
                 cyc, inst_valid, data_valid);
      end else begin
        mon_r = resp_q.pop_front();
        chk("resp_port", 32'(data_valid), 32'(mon_r.is_data));
        chk("resp_rdata", mon_r.is_data ? data_rdata : inst_rdata, mon_r.rdata);
        chk("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (sram_en) begin
      if (sram_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL sram_unexpected @cyc %0d: addr=%h wen=%b, want no access",
                 cyc, sram_addr, sram_wen);
      end else begin
        mon_s = sram_q.pop_front();
        chk("sram_addr", sram_addr, mon_s.addr);
        chk("sram_wen", 32'(sram_wen), 32'(mon_s.wen));
        chk("sram_wdata", sram_wdata, mon_s.wdata);
        chk("sram_cycle", 32'(cyc), 32'(mon_s.cyc));
      end
    end else begin
      chk("sram_idle_bus", sram_addr | sram_wdata | {28'b0, sram_wen}, 32'd0);
    end
  end

  // Holds the port's request until its valid, checking the stall each cycle.
  task automatic wait_port(input bit is_data, input string tag);
    bit v, st, got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      v  = is_data ? data_valid : inst_valid;
      st = is_data ? data_stall : inst_stall;
      chk({tag, "_stall"}, 32'(st), 32'(!v));
      got = v;
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL %s_timeout: valid=0 after 40 cycles, want 1", tag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us");
    $fatal(1, "watchdog");
  end

  logic [31:0] d_a [4];
  logic [31:0] d_w [4];
  logic [31:0] i_a [2];
  logic [31:0] i_w [2];
  int k;

  initial begin
    d_a = '{32'h10010010, 32'h10010014, 32'h10010018, 32'h1001001C};
    d_w = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    i_a = '{32'h00400008, 32'h0040000C};
    i_w = '{32'h240A0003, 32'h240B0004};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sram_en", 32'(sram_en), 32'd0);
    chk("rst_valids", 32'({inst_valid, data_valid}), 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);
    chk("rst_stalls", 32'({inst_stall, data_stall}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single fetch
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h00400000; k = cyc;
    exp_read(1'b0, 32'h00400000, 32'h24080001, k);
    wait_port(1'b0, "t1_inst");
    inst_req = 1'b0;

    // Simultaneous requests: data first, fetch in the next IDLE
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h00400004;
    data_req = 1'b1; data_addr = 32'h10010004; data_wen = 4'b0; k = cyc;
    exp_read(1'b1, 32'h10010004, 32'h11112222, k);
    exp_read(1'b0, 32'h00400004, 32'h24090002, k + LAT + 3);
    fork
      begin wait_port(1'b1, "t2_data"); data_req = 1'b0; end
      begin wait_port(1'b0, "t2_inst"); inst_req = 1'b0; end
    join

    // Starvation: D D I D D I with both requests held
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = d_a[0];
    inst_req = 1'b1; inst_addr = i_a[0]; k = cyc;
    exp_read(1'b1, d_a[0], d_w[0], k);
    exp_read(1'b1, d_a[1], d_w[1], k + 5);
    exp_read(1'b0, i_a[0], i_w[0], k + 10);
    exp_read(1'b1, d_a[2], d_w[2], k + 15);
    exp_read(1'b1, d_a[3], d_w[3], k + 20);
    exp_read(1'b0, i_a[1], i_w[1], k + 25);
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          data_addr = d_a[j]; data_req = 1'b1;
          wait_port(1'b1, "t3_data");
        end
        data_req = 1'b0;
      end
      begin
        for (int j = 0; j < 2; j++) begin
          inst_addr = i_a[j]; inst_req = 1'b1;
          wait_port(1'b0, "t3_inst");
        end
        inst_req = 1'b0;
      end
    join

    // Byte store, data_rdata holds the last load; then read it back
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 32'h10010008; data_wen = 4'b1100;
    data_wdata = 32'hABCD0000; k = cyc;
    exp_write(32'h10010008, 4'b1100, 32'hABCD0000, 32'hD3D3D3D3, k);
    wait_port(1'b1, "t4_store");
    data_req = 1'b0; data_wen = 4'b0; data_wdata = 32'b0;
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 32'h10010008; k = cyc;
    exp_read(1'b1, 32'h10010008, 32'hABCD6666, k);
    wait_port(1'b1, "t4_load");
    data_req = 1'b0;

    // Flush during WAIT drops the fetch; flush in IDLE delays the next grant
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h00400004; k = cyc;
    sram_q.push_back('{32'h00400004, 4'b0, 32'b0, k + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inst_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_drop_valid", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h00400000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; k = cyc;
    exp_read(1'b0, 32'h00400000, 32'h24080001, k);
    wait_port(1'b0, "t5_inst");
    inst_req = 1'b0;

    // Reset during WAIT of a data read aborts it; held request re-granted
    @(posedge clk); #1;
    data_req = 1'b1; data_addr = 32'h10010020; k = cyc;
    sram_q.push_back('{32'h10010020, 4'b0, 32'b0, k + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; k = cyc;
    exp_read(1'b1, 32'h10010020, 32'h77778888, k);
    @(negedge clk);
    chk("t6_sram_en", 32'(sram_en), 32'd0);
    chk("t6_valids", 32'({inst_valid, data_valid}), 32'd0);
    chk("t6_data_rdata", data_rdata, 32'd0);
    chk("t6_inst_rdata", inst_rdata, 32'd0);
    wait_port(1'b1, "t6_data");
    data_req = 1'b0;

    repeat (3) @(posedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("sram_q_drained", 32'(sram_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
